// File: rtl/seq_shifter_pkg.sv
// Shared definitions for the multi-cycle shifter: op codes, FSM states and
// op-code legalisation.
package seq_shifter_pkg;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_LSL  = 3'b001;
  localparam logic [2:0] OP_LSR  = 3'b010;
  localparam logic [2:0] OP_ASR  = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  // Codes above ROR are reserved and behave as PASS.
  function automatic logic [2:0] legal_op(input logic [2:0] op);
    return (op > OP_ROR) ? OP_PASS : op;
  endfunction

endpackage

// File: rtl/seq_shifter_step.sv
// Single-position combinational shift/rotate step; also reports the bit that
// leaves the word.
module shift_step
  import seq_shifter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] value,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] next_value,
  output logic             carry_out
);

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_value = value;
    carry_out  = 1'b0;
    case (op)
      OP_LSL: begin
        next_value = {value[WIDTH-2:0], 1'b0};
        carry_out  = value[WIDTH-1];
      end
      OP_LSR: begin
        next_value = {1'b0, value[WIDTH-1:1]};
        carry_out  = value[0];
      end
      OP_ASR: begin
        next_value = {value[WIDTH-1], value[WIDTH-1:1]};
        carry_out  = value[0];
      end
      OP_ROR: begin
        next_value = {value[0], value[WIDTH-1:1]};
        carry_out  = value[0];
      end
      default: begin
        next_value = value;
        carry_out  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: one bit position per clock between a request and a
// result valid/ready handshake, with carry and zero flags.
module seq_shifter
  import seq_shifter_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_op,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [2:0]       op_q, op_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;

  logic [WIDTH-1:0] step_value;
  logic             step_carry;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .value      (work_q),
    .op         (op_q),
    .next_value (step_value),
    .carry_out  (step_carry)
  );

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = in_data;
          op_d    = legal_op(in_op);
          // PASS needs no steps, so its amount is discarded at accept time.
          cnt_d   = (legal_op(in_op) == OP_PASS) ? '0 : in_amt;
          carry_d = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          work_d  = step_value;
          carry_d = step_carry;
          cnt_d   = cnt_q - AMT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      op_q    <= OP_PASS;
      cnt_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
    end
  end

  // The zero flag is qualified by DONE so it reads 0 out of reset and while
  // the working register still holds intermediate values.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = work_q;
  assign out_carry = carry_q;
  assign out_zero  = (state_q == DONE) && (work_q == '0);

endmodule

// File: tb/tb_seq_shifter.sv
// Directed self-checking bench for seq_shifter: latency, data, flags,
// back-pressure and asynchronous abort.
module tb_seq_shifter;
  import seq_shifter_pkg::*;

  localparam int WIDTH = 16;
  localparam int AMT_W = $clog2(WIDTH);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [2:0]       in_op;
  logic [AMT_W-1:0] in_amt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;
  logic             out_zero;

  int total = 0;
  int bad   = 0;

  seq_shifter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_op     (in_op),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Presents one request (called #1 after an edge, block idle) and then
  // scrambles the inputs to show they are ignored after acceptance.
  task automatic send(input logic [WIDTH-1:0] data, input logic [2:0] op,
                      input logic [AMT_W-1:0] amt);
    check("in_ready_before_send", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = data;
    in_op    = op;
    in_amt   = amt;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = ~data;
    in_op    = OP_LSL;
    in_amt   = '1;
  endtask

  // Waits (bounded) for out_valid; latency counts the accept cycle too.
  task automatic wait_result(input string tag, input int exp_lat);
    int edges = 0;
    while (!out_valid && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    check({tag, "_latency"}, 32'(edges + 1), 32'(exp_lat));
  endtask

  task automatic check_result(input string tag, input logic [WIDTH-1:0] d,
                              input logic c, input logic z);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"},  32'(out_data),  32'(d));
    check({tag, "_carry"}, 32'(out_carry), 32'(c));
    check({tag, "_zero"},  32'(out_zero),  32'(z));
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_valid_after_xfer"}, 32'(out_valid), 32'd0);
    check({tag, "_ready_after_xfer"}, 32'(in_ready),  32'd1);
  endtask

  task automatic run(input string tag, input logic [WIDTH-1:0] data, input logic [2:0] op,
                     input logic [AMT_W-1:0] amt, input int exp_lat,
                     input logic [WIDTH-1:0] exp_d, input logic exp_c, input logic exp_z);
    send(data, op, amt);
    wait_result(tag, exp_lat);
    check_result(tag, exp_d, exp_c, exp_z);
    drain(tag);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_op     = OP_PASS;
    in_amt    = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'h0000);
    check("rst_out_carry", 32'(out_carry), 32'd0);
    check("rst_out_zero",  32'(out_zero),  32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);

    run("lsl1",    16'h8001, OP_LSL, 4'd1,  3,  16'h0002, 1'b1, 1'b0);
    run("asr15",   16'h8000, OP_ASR, 4'd15, 17, 16'hFFFF, 1'b0, 1'b0);
    run("lsr4",    16'h00F0, OP_LSR, 4'd4,  6,  16'h000F, 1'b0, 1'b0);
    run("ror4",    16'h0001, OP_ROR, 4'd4,  6,  16'h1000, 1'b0, 1'b0);
    run("ror1",    16'h0001, OP_ROR, 4'd1,  3,  16'h8000, 1'b1, 1'b0);
    run("op111",   16'h1234, 3'b111, 4'd5,  2,  16'h1234, 1'b0, 1'b0);
    run("lsl0",    16'hABCD, OP_LSL, 4'd0,  2,  16'hABCD, 1'b0, 1'b0);

    // Back-pressure: result must hold steady while the consumer stalls.
    send(16'h0001, OP_LSL, 4'd15);
    wait_result("lsl15", 17);
    check_result("lsl15", 16'h8000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_result("stall", 16'h8000, 1'b0, 1'b0);
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    drain("lsl15");

    run("lsr15",   16'h8000, OP_LSR, 4'd15, 17, 16'h0001, 1'b0, 1'b0);
    run("zero_asr", 16'h0000, OP_ASR, 4'd3, 5,  16'h0000, 1'b0, 1'b1);

    // Abort mid-shift: three steps in, then asynchronous reset.
    send(16'h00FF, OP_LSL, 4'd8);
    repeat (3) @(posedge clk);
    #1;
    check("abort_partial_data", 32'(out_data), 32'h07F8);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_out_data",  32'(out_data),  32'h0000);
    check("abort_out_carry", 32'(out_carry), 32'd0);
    check("abort_out_zero",  32'(out_zero),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    run("pass_after_abort", 16'h5A5A, OP_PASS, 4'd9, 2, 16'h5A5A, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
